zigzag_cavlc_prep: RTL and testbench

- Sits directly downstream of the transform coder. Consumes one 4x4 block of quantized coefficients, held in parallel as `processedres[15:0]`, raster order, index = row*4+col.
- Emits the coefficients serially in H.264 frame zigzag order over a valid/ready handshake.
- Alongside the stream, presents the per-block CAVLC statistics that the downstream entropy coder needs: TotalCoeff, TrailingOnes and TotalZeros.

---
 rtl/zigzag_cavlc_prep.sv | 127 ++++++++++++
 tb/tb_zigzag_cavlc_prep.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/zigzag_cavlc_prep.sv
// Serializes a 4x4 quantized coefficient block in H.264 frame zigzag order and
// presents the CAVLC block statistics (TotalCoeff, TrailingOnes, TotalZeros).
module zigzag_cavlc_prep #(
  parameter int BIT_LENGTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BIT_LENGTH:0]   coeffs [15:0],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIT_LENGTH:0]   coef_out,
  output logic [3:0]            coef_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones,
  output logic [3:0]            total_zeros,
  output logic                  stats_valid
);

  typedef enum logic [1:0] {IDLE, ANALYZE, STREAM} state_t;

  localparam logic [BIT_LENGTH:0] ONE  = {{BIT_LENGTH{1'b0}}, 1'b1};
  localparam logic [BIT_LENGTH:0] MONE = '1;

  state_t              state, state_nx;
  logic [BIT_LENGTH:0] zbuf [16];
  logic [3:0]          pos;
  logic                accept, xfer;

  logic [4:0]          nz_cnt, last_p1;
  logic [1:0]          t1_cnt;
  logic                t1_done;
  logic [3:0]          tz_c;

  // Scan position -> raster index.
  function automatic logic [3:0] zz(input logic [3:0] p);
    case (p)
      4'd0:  zz = 4'd0;   4'd1:  zz = 4'd1;   4'd2:  zz = 4'd4;   4'd3:  zz = 4'd8;
      4'd4:  zz = 4'd5;   4'd5:  zz = 4'd2;   4'd6:  zz = 4'd3;   4'd7:  zz = 4'd6;
      4'd8:  zz = 4'd9;   4'd9:  zz = 4'd12;  4'd10: zz = 4'd13;  4'd11: zz = 4'd10;
      4'd12: zz = 4'd7;   4'd13: zz = 4'd11;  4'd14: zz = 4'd14;  default: zz = 4'd15;
    endcase
  endfunction

  assign in_ready  = enable && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == STREAM);
  assign xfer      = out_valid && out_ready && enable;
  assign out_last  = out_valid && (pos == 4'd15);
  assign coef_out  = zbuf[pos];
  assign coef_pos  = pos;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ANALYZE;
      ANALYZE: state_nx = STREAM;
      STREAM:  if (xfer && pos == 4'd15) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= state_nx;
  end

  // Statistics over the already-reordered buffer.
  always_comb begin
    nz_cnt  = '0;
    last_p1 = '0;
    t1_cnt  = '0;
    t1_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (zbuf[i] != '0) begin
        nz_cnt  = nz_cnt + 5'd1;
        last_p1 = 5'(i + 1);
      end
    end
    // Walk backwards over nonzeros; stop at first |x|>1 or at three ones.
    for (int i = 15; i >= 0; i--) begin
      if (zbuf[i] != '0 && !t1_done) begin
        if ((zbuf[i] == ONE || zbuf[i] == MONE) && t1_cnt != 2'd3)
          t1_cnt = t1_cnt + 2'd1;
        else
          t1_done = 1'b1;
      end
    end
    tz_c = 4'(last_p1 - nz_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) zbuf[i] <= '0;
      pos           <= '0;
      total_coeff   <= '0;
      trailing_ones <= '0;
      total_zeros   <= '0;
      stats_valid   <= 1'b0;
    end else if (enable) begin
      if (accept)
        for (int i = 0; i < 16; i++) zbuf[i] <= coeffs[zz(4'(i))];
      case (state)
        ANALYZE: begin
          total_coeff   <= nz_cnt;
          trailing_ones <= t1_cnt;
          total_zeros   <= tz_c;
          stats_valid   <= 1'b1;
          pos           <= '0;
        end
        STREAM: if (xfer) begin
          if (pos == 4'd15) begin
            stats_valid <= 1'b0;
            pos         <= '0;
          end else begin
            pos <= pos + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_cavlc_prep.sv
// Directed bench for zigzag_cavlc_prep with a spec-level reference model and
// a per-cycle stream monitor.
module tb_zigzag_cavlc_prep;

  typedef int blk_t [16];

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, out_ready;
  logic [31:0] coeffs [15:0];
  logic        in_ready, out_valid, out_last, stats_valid;
  logic [31:0] coef_out;
  logic [3:0]  coef_pos;
  logic [4:0]  total_coeff;
  logic [1:0]  trailing_ones;
  logic [3:0]  total_zeros;

  int n_chk = 0, n_fail = 0;
  int zzt [16] = '{0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15};
  blk_t exp_q;
  int exp_tc, exp_t1, exp_tz, exp_pos, nxfer;

  zigzag_cavlc_prep #(.BIT_LENGTH(31)) dut (
    .clk(clk), .reset(reset), .enable(enable), .coeffs(coeffs),
    .in_valid(in_valid), .in_ready(in_ready), .coef_out(coef_out),
    .coef_pos(coef_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .total_coeff(total_coeff), .trailing_ones(trailing_ones),
    .total_zeros(total_zeros), .stats_valid(stats_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: reorder, then derive statistics from the list of nonzeros.
  function automatic void model(input blk_t r, output blk_t q, output int tc, output int t1, output int tz);
    int nzv[$];
    int last;
    last = -1;
    for (int i = 0; i < 16; i++) begin
      q[i] = r[zzt[i]];
      if (q[i] != 0) begin nzv.push_back(q[i]); last = i; end
    end
    tc = nzv.size();
    tz = (tc == 0) ? 0 : last + 1 - tc;
    t1 = 0;
    while (nzv.size() > 0) begin
      int v;
      v = nzv.pop_back();
      if ((v == 1 || v == -1) && t1 < 3) t1++;
      else break;
    end
  endfunction

  // Stream monitor: every valid beat must match the model.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      chk("stats_valid", stats_valid, 1);
      chk("total_coeff", total_coeff, exp_tc);
      chk("trailing_ones", trailing_ones, exp_t1);
      chk("total_zeros", total_zeros, exp_tz);
      chk("in_ready_stream", in_ready, 0);
      if (exp_pos > 15) chk("extra_beat", 1, 0);
      else begin
        chk("coef_pos", coef_pos, exp_pos);
        chk("coef_out", coef_out, exp_q[exp_pos]);
        chk("out_last", out_last, exp_pos == 15);
      end
      if (out_ready && enable) begin nxfer++; exp_pos++; end
    end
  end

  // mode 0: ready=1; 1: ready 1,0,0 pattern; 2: enable stall at pos 5 + in_valid
  // during stream; 3: reset at pos 9.
  task automatic run_block(input blk_t r, input int mode);
    int cyc;
    bit stalled;
    model(r, exp_q, exp_tc, exp_t1, exp_tz);
    exp_pos = 0; nxfer = 0;
    for (int i = 0; i < 16; i++) coeffs[i] = r[i];
    in_valid = 1; out_ready = 1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("analyze_out_valid", out_valid, 0);
    chk("analyze_stats_valid", stats_valid, 0);
    chk("analyze_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("c2_stats_valid", stats_valid, 1);
    chk("c2_out_valid", out_valid, 1);
    cyc = 0; stalled = 0;
    while (nxfer < 16 && cyc < 200) begin
      if (mode == 3 && nxfer == 9) begin
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stats_valid", stats_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coef_pos", coef_pos, 0);
        chk("rst_coef_out", coef_out, 0);
        chk("rst_total_coeff", total_coeff, 0);
        return;
      end
      if (mode == 2 && nxfer == 5 && !stalled) begin
        stalled = 1;
        enable = 0; in_valid = 1;
        for (int i = 0; i < 16; i++) coeffs[i] = 32'h55;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          chk("stall_pos", coef_pos, 5);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
        end
        enable = 1;
      end
      out_ready = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("xfer_count", nxfer, 16);
    chk("end_out_valid", out_valid, 0);
    chk("end_stats_valid", stats_valid, 0);
    chk("end_in_ready", in_ready, 1);
  endtask

  initial begin
    blk_t ba, bb, bc, bd, q;
    int tc, t1, tz;
    for (int i = 0; i < 16; i++) begin
      ba[i] = 128; bb[i] = 0; bc[i] = 1; bd[i] = 0; coeffs[i] = '0;
    end
    bb[0] = 7; bb[1] = -1; bb[8] = 2; bb[2] = 1; bb[3] = -1;

    // Hand-computed pins on the model itself.
    model(ba, q, tc, t1, tz);
    chk("mA_tc", tc, 16); chk("mA_t1", t1, 0); chk("mA_tz", tz, 0);
    model(bb, q, tc, t1, tz);
    chk("mB_tc", tc, 5); chk("mB_t1", t1, 2); chk("mB_tz", tz, 2);
    chk("mB_q3", q[3], 2); chk("mB_q6", q[6], 32'hFFFF_FFFF); chk("mB_q2", q[2], 0);
    model(bc, q, tc, t1, tz);
    chk("mC_tc", tc, 16); chk("mC_t1", t1, 3); chk("mC_tz", tz, 0);
    model(bd, q, tc, t1, tz);
    chk("mD_tc", tc, 0); chk("mD_t1", t1, 0); chk("mD_tz", tz, 0);

    reset = 1; enable = 1; in_valid = 0; out_ready = 1;
    exp_pos = 0; nxfer = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_stats_valid", stats_valid, 0);
    chk("reset_coef_out", coef_out, 0);
    chk("reset_coef_pos", coef_pos, 0);
    chk("reset_total_coeff", total_coeff, 0);
    chk("reset_trailing_ones", trailing_ones, 0);
    chk("reset_total_zeros", total_zeros, 0);

    run_block(ba, 0);
    run_block(bb, 0);
    run_block(bc, 0);
    run_block(bd, 0);
    run_block(bb, 1);
    run_block(ba, 2);
    run_block(bc, 3);
    run_block(bb, 0);
    repeat (3) @(posedge clk);
    #1 chk("idle_out_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
